// File: rtl/fb_read_server.sv
// Dual-framebuffer byte store serving 10-byte VGA reads with a queued write path.
// Optional FB_READ_SERVER_STALL_CNT_EN adds a saturating drain-stall counter output.
module fb_read_server #(
  parameter int WR_FIFO_DEPTH = 4,
  parameter int ROW_BYTES     = 256,
  parameter int NUM_ROWS      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_bytes,
  input  logic [39:0] mem_addr,
  output logic [79:0] input_bytes,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [16:0] wr_addr,
  input  logic [7:0]  wr_data,
`ifdef FB_READ_SERVER_STALL_CNT_EN
  output logic        wr_fifo_empty,
  output logic [15:0] stall_cnt
`else
  output logic        wr_fifo_empty
`endif
);

  localparam int NUM_BANKS    = 16;
  localparam int READ_BYTES   = 10;
  localparam int BANK_ENTRIES = 2 * NUM_ROWS * ROW_BYTES / NUM_BANKS;
  localparam int PTR_W        = $clog2(WR_FIFO_DEPTH);
  localparam int CNT_W        = $clog2(WR_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  // ---------------------------------------------------------------------------
  // Write queue
  // ---------------------------------------------------------------------------
  wr_entry_t        fifo_mem [WR_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ready_q, wr_ready_d;
  logic             empty_q, empty_d;
  logic             push, pop;
  wr_entry_t        head;

  assign push = wr_valid && wr_ready_q;
  // Reads own the banks outright; the queue only drains on read-idle cycles.
  assign pop  = !read_bytes && (count_q != '0);
  assign head = fifo_mem[rd_ptr_q];

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wr_ready_d = (count_d < CNT_W'(WR_FIFO_DEPTH));
    empty_d    = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      empty_q    <= empty_d;
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers
  // and count, so clearing the contents would only cost logic.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
  end

  assign wr_ready      = wr_ready_q;
  assign wr_fifo_empty = empty_q;

  // ---------------------------------------------------------------------------
  // Banked framebuffer storage: bank = col[3:0], entry = {fb, row, col[7:4]}
  // ---------------------------------------------------------------------------
  logic [7:0] bank_mem [NUM_BANKS][BANK_ENTRIES];

  always_ff @(posedge clk) begin
    if (pop) bank_mem[head.addr[3:0]][head.addr[16:4]] <= head.data;
  end

  // ---------------------------------------------------------------------------
  // Read path: one entry per bank, then rotate banks into byte lanes
  // ---------------------------------------------------------------------------
  logic [8:0]  rd_fbrow;
  logic [3:0]  rd_grp;
  logic [3:0]  rd_lane0;
  logic [3:0]  bank_grp [NUM_BANKS];
  logic [7:0]  bank_rd  [NUM_BANKS];
  logic [3:0]  lane;
  logic [8:0]  col_sum;
  logic [79:0] input_bytes_q, input_bytes_d;
  logic        unused_addr_bits;

  assign rd_fbrow         = mem_addr[16:8];
  assign rd_grp           = mem_addr[7:4];
  assign rd_lane0         = mem_addr[3:0];
  assign unused_addr_bits = ^mem_addr[39:17];

  always_comb begin
    input_bytes_d = '0;
    lane          = '0;
    col_sum       = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      // Banks below the start lane hold the bytes that spilled into the next group.
      bank_grp[b] = (4'(b) >= rd_lane0) ? rd_grp : rd_grp + 4'd1;
      bank_rd[b]  = bank_mem[b][{rd_fbrow, bank_grp[b]}];
    end
    for (int i = 0; i < READ_BYTES; i++) begin
      lane    = rd_lane0 + 4'(i);
      col_sum = {1'b0, mem_addr[7:0]} + 9'(i);
      // Bytes past the row end read as zero; the wrapped group fetch is discarded.
      if (!col_sum[8]) input_bytes_d[8*i +: 8] = bank_rd[lane];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_bytes_q <= '0;
    end else if (read_bytes) begin
      input_bytes_q <= input_bytes_d;
    end
  end

  assign input_bytes = input_bytes_q;

`ifdef FB_READ_SERVER_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Cycles where a pending write was blocked by a read; saturating
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (read_bytes && (count_q != '0) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
